// File: rtl/core_pkg.sv
// Shared LSU definitions: RV64I load/store funct3 codes
// and the memory-interface FSM state type.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte strobes,
// store lane shift, load extract + sign/zero extension.
// In : i_f3, i_we, i_off, i_wdata, i_rdata
// Out: o_ok, o_wstrb, o_wdata, o_ldata
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic        i_we,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic        o_ok,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_wdata,
  output logic [63:0] o_ldata
);

  logic        w_legal;
  logic        w_align;
  logic [63:0] w_sh;

  // 111 never exists; stores have no unsigned forms
  assign w_legal = (i_f3 != 3'b111) && !(i_we && i_f3[2]);

  always_comb begin
    w_align = 1'b1;
    o_wstrb = 8'h00;
    unique case (i_f3[1:0])
      2'b00: begin
        w_align = 1'b1;
        o_wstrb = 8'h01 << i_off;
      end
      2'b01: begin
        w_align = !i_off[0];
        o_wstrb = 8'h03 << i_off;
      end
      2'b10: begin
        w_align = (i_off[1:0] == 2'b00);
        o_wstrb = 8'h0F << i_off;
      end
      default: begin
        w_align = (i_off == 3'b000);
        o_wstrb = 8'hFF;
      end
    endcase
  end

  assign o_ok    = w_legal && w_align;
  assign o_wdata = i_wdata << {i_off, 3'b000};
  assign w_sh    = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_ldata = '0;
    unique case (i_f3)
      F3_B:    o_ldata = {{56{w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_ldata = {{48{w_sh[15]}}, w_sh[15:0]};
      F3_W:    o_ldata = {{32{w_sh[31]}}, w_sh[31:0]};
      F3_D:    o_ldata = w_sh;
      F3_BU:   o_ldata = {56'd0, w_sh[7:0]};
      F3_HU:   o_ldata = {48'd0, w_sh[15:0]};
      F3_WU:   o_ldata = {32'd0, w_sh[31:0]};
      default: o_ldata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the M stage to a valid/ready
// data-memory port with variable latency and a timeout.
// Pipe : req_valid_M/req_we_M/funct3_M/addr_M/wdata_M in,
//        rdata_M/done_M/stall_M/misalign_M/bus_err_M out
// Mem  : mem_req_valid/mem_we/mem_addr/mem_wdata/mem_wstrb out,
//        mem_req_ready/mem_rsp_valid/mem_rdata in
module lsu_mem_if
  import core_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_M,
  input  logic              req_we_M,
  input  logic [2:0]        funct3_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [63:0]       wdata_M,
  output logic [63:0]       rdata_M,
  output logic              done_M,
  output logic              stall_M,
  output logic              misalign_M,
  output logic              bus_err_M,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rdata
);

  localparam int CW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;
  logic [63:0]       r_rdata;

  logic              w_idle;
  logic [2:0]        w_f3;
  logic              w_we;
  logic [2:0]        w_off;
  logic              w_ok;
  logic [7:0]        w_wstrb;
  logic [63:0]       w_wdata;
  logic [63:0]       w_ldata;
  logic              w_accept;
  logic              w_timeout;

  // one align unit: live inputs in IDLE, latched fields after
  assign w_idle = (r_state == IDLE);
  assign w_f3   = w_idle ? funct3_M    : r_f3;
  assign w_we   = w_idle ? req_we_M    : r_we;
  assign w_off  = w_idle ? addr_M[2:0] : r_addr[2:0];

  lsu_align u_align (
    .i_f3    (w_f3),
    .i_we    (w_we),
    .i_off   (w_off),
    .i_wdata (wdata_M),
    .i_rdata (mem_rdata),
    .o_ok    (w_ok),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  assign w_accept  = req_valid_M && w_ok;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_next        = r_state;
    stall_M       = 1'b0;
    misalign_M    = 1'b0;
    bus_err_M     = 1'b0;
    done_M        = 1'b0;
    mem_req_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid_M) begin
          stall_M    = w_ok;
          misalign_M = !w_ok;
          if (w_ok) w_next = REQ;
        end
      end
      REQ: begin
        stall_M       = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        stall_M = 1'b1;
        if (mem_rsp_valid) begin
          w_next = DONE;
        end else if (w_timeout) begin
          bus_err_M = 1'b1;
          w_next    = DONE;
        end
      end
      default: begin
        done_M = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we_M;
            r_f3    <= funct3_M;
            r_addr  <= addr_M;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
          end
        end
        REQ: begin
          if (mem_req_ready) r_cnt <= '0;
        end
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (mem_rsp_valid) begin
            r_rdata <= r_we ? 64'd0 : w_ldata;
          end else if (w_timeout) begin
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_M   = r_rdata;
  assign mem_we    = r_we;
  assign mem_addr  = {r_addr[ADDR_W-1:3], 3'b000};
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

endmodule
